lu_or_nor_queue: RTL and testbench

//  Issue stage feeding the OR/NOR logic unit. Accepts operand pairs plus select over a valid/ready handshake.

---
 rtl/lu_pkg.sv | 26 ++
 rtl/lu_or_nor_vec.sv | 21 ++
 rtl/lu_or_nor_queue.sv | 109 ++++++++++
 tb/tb_lu_or_nor_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the OR/NOR logic unit issue stage.
package lu_pkg;

    localparam logic SEL_OR  = 1'b0;
    localparam logic SEL_NOR = 1'b1;

    // Default datapath width; the queue itself is parameterised separately.
    localparam int LU_WIDTH = 8;

    typedef struct packed {
        logic                sel;
        logic [LU_WIDTH-1:0] res;
    } lu_entry_t;

    // Reference OR/NOR at the default width.
    function automatic logic [LU_WIDTH-1:0] lu_apply(
        input logic [LU_WIDTH-1:0] a,
        input logic [LU_WIDTH-1:0] b,
        input logic                sel
    );
        logic [LU_WIDTH-1:0] v;
        v = a | b;
        return (sel == SEL_NOR) ? ~v : v;
    endfunction

endpackage

// File: rtl/lu_or_nor_vec.sv
// WIDTH-bit combinational OR (sel=0) / NOR (sel=1).
module lu_or_nor_vec
    import lu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH-1:0] or_v;

    // Bitwise OR, optionally inverted for NOR.
    always_comb begin
        or_v = a | b;
        res  = (sel == SEL_NOR) ? ~or_v : or_v;
    end

endmodule

// File: rtl/lu_or_nor_queue.sv
// Issue stage: computes OR/NOR on entry and buffers results in a small FIFO.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on occupancy (no bypass, a full FIFO refuses a
// push even when a pop happens in the same cycle); out_* depend only on stored
// state, so there is no combinational path from in_* to out_*. flush wins over
// both transfers in the same cycle.
module lu_or_nor_queue
    import lu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_res,
    output logic                     out_sel,
    output logic                     out_zero,
    output logic [CNT_W-1:0]         op_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] res;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] vec_res;
    logic             push;
    logic             pop;
    entry_t           head;

    lu_or_nor_vec #(.WIDTH(WIDTH)) u_vec (
        .a   (in_a),
        .b   (in_b),
        .sel (in_sel),
        .res (vec_res)
    );

    // Handshake qualification; flush suppresses both transfers.
    always_comb begin
        in_ready  = (level != LVL_FULL);
        out_valid = (level != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
    end

    // Storage array: written on push only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{sel: in_sel, res: vec_res};
        end
    end

    // Pointers, occupancy and completed-op counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            op_count <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            op_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (op_count != '1) begin
                    op_count <= op_count + CNT_W'(1);
                end
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Head-of-queue view, forced to zero while empty.
    always_comb begin
        head     = mem[rd_ptr];
        out_res  = out_valid ? head.res : '0;
        out_sel  = out_valid ? head.sel : 1'b0;
        out_zero = out_valid && (head.res == '0);
    end

endmodule

// File: tb/tb_lu_or_nor_queue.sv
// Self-checking bench for lu_or_nor_queue (WIDTH=8, DEPTH=4).
module tb_lu_or_nor_queue;

    localparam int W = 8;
    localparam int D = 4;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_sel;
    logic         out_zero;
    logic [C-1:0] op_count;
    logic [2:0]   level;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Behavioural model: a queue of {sel, result} plus a saturating counter.
    logic [W:0]   exp_q[$];
    logic [C-1:0] m_count;

    lu_or_nor_queue #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_sel   (out_sel),
        .out_zero  (out_zero),
        .op_count  (op_count),
        .level     (level)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update at each edge; reset clears it at once.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_count = '0;
        end else if (flush) begin
            exp_q.delete();
            m_count = '0;
        end else begin
            bit do_push, do_pop;
            logic [W-1:0] r;
            do_push = in_valid && (exp_q.size() != D);
            do_pop  = out_ready && (exp_q.size() != 0);
            r = in_sel ? ~(in_a | in_b) : (in_a | in_b);
            if (do_pop) begin
                void'(exp_q.pop_front());
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end
            if (do_push) exp_q.push_back({in_sel, r});
        end
    end

    // Compare process: every falling edge while enabled.
    always @(negedge clk) begin
        if (check_en) begin
            logic [W:0] h;
            h = (exp_q.size() != 0) ? exp_q[0] : '0;
            check("cmp_level",     32'(level),     32'(exp_q.size()));
            check("cmp_in_ready",  32'(in_ready),  32'(exp_q.size() != D));
            check("cmp_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("cmp_out_res",   32'(out_res),   32'(h[W-1:0]));
            check("cmp_out_sel",   32'(out_sel),   32'(h[W]));
            check("cmp_out_zero",  32'(out_zero),  32'((exp_q.size() != 0) && (h[W-1:0] == '0)));
            check("cmp_op_count",  32'(op_count),  32'(m_count));
        end
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_sel   = s;
    endtask

    initial begin
        logic [W-1:0] exp_pops [4];
        exp_pops[0] = 8'h0C; exp_pops[1] = 8'h30; exp_pops[2] = 8'hC0; exp_pops[3] = 8'h33;

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, '0, '0, 1'b0);
        #3;
        // Reset values with no clock edge yet.
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res",   32'(out_res),   32'h00);
        check("rst_level",     32'(level),     32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        check_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Compute: OR then NOR.
        set_in(1'b1, 8'h0F, 8'h30, 1'b0);
        tick();
        check("or_res",  32'(out_res),  32'h3F);
        check("or_sel",  32'(out_sel),  32'd0);
        check("or_zero", 32'(out_zero), 32'd0);
        set_in(1'b0, '0, '0, 1'b0); out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        set_in(1'b1, 8'hFF, 8'h00, 1'b1);
        tick();
        check("nor_res",  32'(out_res),  32'h00);
        check("nor_zero", 32'(out_zero), 32'd1);
        check("nor_sel",  32'(out_sel),  32'd1);
        set_in(1'b0, '0, '0, 1'b0); out_ready = 1'b1;
        tick();
        check("pop_count", 32'(op_count), 32'd2);

        // Full / ordering, 5th pair held off.
        out_ready = 1'b0;
        set_in(1'b1, 8'h01, 8'h02, 1'b0); tick();
        set_in(1'b1, 8'h04, 8'h08, 1'b0); tick();
        set_in(1'b1, 8'h10, 8'h20, 1'b0); tick();
        set_in(1'b1, 8'h40, 8'h80, 1'b0); tick();
        check("full_level", 32'(level),    32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        set_in(1'b1, 8'h11, 8'h22, 1'b0);
        tick(); tick();
        check("full_hold_level", 32'(level),   32'd4);
        check("full_head",       32'(out_res), 32'h03);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) set_in(1'b0, '0, '0, 1'b0);
            check("order_pop", 32'(out_res), 32'(exp_pops[i]));
        end
        tick();
        check("order_empty", 32'(out_valid), 32'd0);
        check("order_count", 32'(op_count),  32'd7);

        // Simultaneous push/pop with wrap, counter from zero.
        out_ready = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
        check("flush_count0", 32'(op_count), 32'd0);
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, W'($urandom), W'($urandom), 1'($urandom)); tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, W'($urandom), W'($urandom), 1'($urandom)); tick();
            check("wrap_level", 32'(level), 32'd2);
        end
        check("wrap_count", 32'(op_count), 32'd6);

        // Flush beats push and pop.
        out_ready = 1'b0;
        set_in(1'b1, 8'h12, 8'h34, 1'b0); tick();
        check("pre_flush_level", 32'(level), 32'd3);
        set_in(1'b1, 8'hAA, 8'h00, 1'b0); out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; set_in(1'b0, '0, '0, 1'b0);
        check("flush_level", 32'(level),     32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_count", 32'(op_count),  32'd0);
        tick();
        check("flush_absent", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 8'h01, 8'h10, 1'b0); tick();
        end
        set_in(1'b0, '0, '0, 1'b0);
        check("arst_pre_level", 32'(level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(in_ready),  32'd1);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_res",   32'(out_res),   32'h00);
        check("arst_level", 32'(level),     32'd0);
        check("arst_count", 32'(op_count),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit hold;
            hold = in_valid && (exp_q.size() == D);
            if (!hold) set_in(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            tick();
        end
        flush = 1'b0; set_in(1'b0, '0, '0, 1'b0); out_ready = 1'b1;
        for (int i = 0; i < D + 1; i++) tick();
        check("drain_empty", 32'(out_valid), 32'd0);

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
